score_pulse_sequencer: RTL



---
 rtl/score_pulse_sequencer_if.sv | 13 +
 rtl/score_pulse_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/score_pulse_sequencer_if.sv
// Event posting port between game logic (master) and the score pulse sequencer (slave).
interface score_pulse_sequencer_if #(
  parameter int AMT_W = 8
);
  logic             evValid;
  logic [AMT_W-1:0] evAmount;
  logic             evDec;
  logic             evReady;
  logic             dropped;

  modport master (output evValid, evAmount, evDec, input evReady, dropped);
  modport slave  (input evValid, evAmount, evDec, output evReady, dropped);
endinterface

// File: rtl/score_pulse_sequencer.sv
// Queues score events and replays each one as a train of single-cycle
// increase/decrease pulses for the BCD score counter. Decrement trains stop
// as soon as the counter reports zero.
//
//  state | meaning
//  IDLE  | no train running; pops the FIFO head when one is waiting
//  PULSE | candidate step pulse this cycle
//  WAIT  | inter-pulse gap; gapCnt counts down to the next PULSE
module score_pulse_sequencer #(
  parameter int DEPTH = 4,
  parameter int AMT_W = 8,
  parameter int GAP   = 0
) (
  input  logic                   clk,
  input  logic                   resetN,
  score_pulse_sequencer_if.slave ev,
  input  logic                   clearAll,
  input  logic                   counterZero,
  output logic                   increase,
  output logic                   decrease,
  output logic                   busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // gapCnt holds at most GAP-1; keep one bit minimum so GAP = 0/1 still elaborate
  localparam int GAP_W = (GAP < 2) ? 1 : $clog2(GAP);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state, stateNext;

  logic [AMT_W:0]   mem [DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [CNT_W-1:0] count;
  logic             ready, empty, push, pop;
  logic [AMT_W-1:0] headAmount;
  logic             headDec;

  logic [AMT_W-1:0] remaining, remainingNext;
  logic             curDec, curDecNext;
  logic [GAP_W-1:0] gapCnt, gapCntNext;

  assign empty       = (count == '0);
  assign ready       = (count != FULL);
  assign ev.evReady  = ready;
  // dropped uses the pre-clear ready so a push lost to a full FIFO is still flagged
  assign ev.dropped  = ev.evValid && !ready;
  assign push        = ev.evValid && ready && !clearAll;
  assign pop         = (state == IDLE) && !empty && !clearAll;
  assign {headAmount, headDec} = mem[rdPtr];

  // FIFO storage: write the offered event at the accepting edge
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr] <= {ev.evAmount, ev.evDec};
    end
  end

  // FIFO pointers and occupancy; clearAll empties the queue
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (clearAll) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // State register together with the train bookkeeping registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      remaining <= '0;
      curDec    <= 1'b0;
      gapCnt    <= '0;
    end else begin
      state     <= stateNext;
      remaining <= remainingNext;
      curDec    <= curDecNext;
      gapCnt    <= gapCntNext;
    end
  end

  // Next-state logic: load a train from the FIFO, count it down, honour the gap
  always_comb begin
    stateNext     = state;
    remainingNext = remaining;
    curDecNext    = curDec;
    gapCntNext    = gapCnt;
    if (clearAll) begin
      stateNext     = IDLE;
      remainingNext = '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            remainingNext = headAmount;
            curDecNext    = headDec;
            // a zero-amount entry is simply discarded
            if (headAmount != '0) stateNext = PULSE;
          end
        end
        PULSE: begin
          if (curDec && counterZero) begin
            remainingNext = '0;
            stateNext     = IDLE;
          end else begin
            remainingNext = remaining - AMT_W'(1);
            if (remaining == AMT_W'(1)) begin
              stateNext = IDLE;
            end else if (GAP == 0) begin
              stateNext = PULSE;
            end else begin
              gapCntNext = GAP_W'(GAP - 1);
              stateNext  = WAIT;
            end
          end
        end
        WAIT: begin
          if (gapCnt == '0) stateNext = PULSE;
          else              gapCntNext = gapCnt - GAP_W'(1);
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // Outputs decoded from state; counterZero gates a decrement combinationally
  always_comb begin
    increase = 1'b0;
    decrease = 1'b0;
    if (state == PULSE) begin
      increase = !curDec;
      decrease = curDec && !counterZero;
    end
    busy = (state != IDLE) || !empty;
  end

endmodule
